// File: rtl/sar_search_if.sv
// Handshake and comparator bus for the successive-approximation searcher.
// master is the searcher side; slave is the comparator/requester side.
interface sar_search_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic             start_ready;
    logic [WIDTH-1:0] trial;
    logic             trial_valid;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [5:0]       probes;
    logic             err;

    modport master (
        input  start, cmp_lt, cmp_eq, cmp_gt,
        output start_ready, trial, trial_valid, done, result, probes, err
    );

    modport slave (
        output start, cmp_lt, cmp_eq, cmp_gt,
        input  start_ready, trial, trial_valid, done, result, probes, err
    );
endinterface

// File: rtl/sar_search.sv
// MSB-first binary search for an operand that is only observable through an
// external magnitude comparator; reports the recovered value and probe count.
module sar_search #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CMP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    sar_search_if.master bus
);
    localparam int unsigned KW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PROBE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] trial_q;
    logic [WIDTH-1:0] result_q;
    logic [KW-1:0]    k_q;
    logic [1:0]       cnt_q;
    logic [5:0]       probes_q;
    logic             err_q;

    logic [WIDTH-1:0] probe_code;
    logic [WIDTH-1:0] acc_upd;
    logic             busy;
    logic             sample;
    logic             one_hot;

    assign probe_code = acc_q | (WIDTH'(1) << k_q);
    assign busy       = (state_q == PROBE) || (state_q == WAIT);
    assign sample     = ((state_q == PROBE) && (CMP_LAT == 0)) ||
                        ((state_q == WAIT) && (cnt_q == 2'd0));
    assign one_hot    = ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b100) ||
                        ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b010) ||
                        ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b001);
    // lt means the trial bit belongs in the answer; gt drops it.
    assign acc_upd    = bus.cmp_lt ? probe_code : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            probes_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        acc_q    <= '0;
                        k_q      <= KW'(WIDTH - 1);
                        probes_q <= '0;
                        err_q    <= 1'b0;
                        state_q  <= PROBE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                PROBE: begin
                    trial_q <= probe_code;
                    if (CMP_LAT != 0) begin
                        cnt_q   <= 2'(CMP_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
                end
                default: state_q <= IDLE;
            endcase

            // Sampling overrides the per-state transition chosen above.
            if (sample) begin
                probes_q <= probes_q + 6'd1;
                if (!one_hot) begin
                    err_q    <= 1'b1;
                    result_q <= acc_q;
                    state_q  <= DONE;
                end else if (bus.cmp_eq) begin
                    result_q <= probe_code;
                    state_q  <= DONE;
                end else begin
                    acc_q <= acc_upd;
                    if (k_q == '0) begin
                        result_q <= acc_upd;
                        state_q  <= DONE;
                    end else begin
                        k_q     <= k_q - KW'(1);
                        state_q <= PROBE;
                    end
                end
            end
        end
    end

    assign bus.start_ready = !busy;
    assign bus.trial       = busy ? probe_code : trial_q;
    assign bus.trial_valid = busy;
    // DONE never lasts more than one cycle, so it doubles as the pulse.
    assign bus.done        = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.probes      = probes_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparators, expected results
// queued at start and checked when done pulses.
module tb_sar_search;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sar_search_if #(.WIDTH(16)) bus0 ();
    sar_search_if #(.WIDTH(16)) bus2 ();

    sar_search #(.WIDTH(16), .CMP_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sar_search #(.WIDTH(16), .CMP_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [15:0] unk0 = '0;
    logic [15:0] unk2 = '0;
    bit          inject = 1'b0;
    bit          sel = 1'b0;

    // Comparator models; inject forces an illegal lt+eq on trial 0x6000.
    always_comb begin
        bus0.cmp_lt = bus0.trial < unk0;
        bus0.cmp_eq = bus0.trial == unk0;
        bus0.cmp_gt = bus0.trial > unk0;
        if (inject && bus0.trial == 16'h6000) begin
            bus0.cmp_lt = 1'b1;
            bus0.cmp_eq = 1'b1;
            bus0.cmp_gt = 1'b0;
        end
    end

    assign bus2.cmp_lt = bus2.trial < unk2;
    assign bus2.cmp_eq = bus2.trial == unk2;
    assign bus2.cmp_gt = bus2.trial > unk2;

    logic        done_s, valid_s, ready_s, err_s;
    logic [15:0] trial_s, result_s;
    logic [5:0]  probes_s;

    always_comb begin
        done_s   = sel ? bus2.done        : bus0.done;
        valid_s  = sel ? bus2.trial_valid : bus0.trial_valid;
        ready_s  = sel ? bus2.start_ready : bus0.start_ready;
        err_s    = sel ? bus2.err         : bus0.err;
        trial_s  = sel ? bus2.trial       : bus0.trial;
        result_s = sel ? bus2.result      : bus0.result;
        probes_s = sel ? bus2.probes      : bus0.probes;
    end

    typedef struct {
        logic [15:0] result;
        logic [5:0]  probes;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_start(input logic v);
        if (sel) bus2.start = v;
        else bus0.start = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trial"}, trial_s, 0);
        check({tag, "_valid"}, valid_s, 0);
        check({tag, "_done"}, done_s, 0);
        check({tag, "_result"}, result_s, 0);
        check({tag, "_probes"}, probes_s, 0);
        check({tag, "_err"}, err_s, 0);
        check({tag, "_ready"}, ready_s, 1);
    endtask

    // One search: queue expectation, launch, wait (bounded) for done, compare.
    task automatic run(input bit s, input string tag, input logic [15:0] unk,
                       input logic [15:0] er, input int ep, input bit eerr,
                       input bit inj, input bit poke);
        exp_t        e;
        int          cyc;
        int          changes;
        logic [15:0] prev;
        sel = s;
        e.result = er;
        e.probes = 6'(ep);
        e.err    = eerr;
        e.lat    = ep * (s ? 3 : 1);
        sb.push_back(e);
        if (s) unk2 = unk;
        else unk0 = unk;
        inject = inj;
        #1;
        check({tag, "_ready"}, ready_s, 1);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check({tag, "_first_trial"}, {valid_s, trial_s}, {1'b1, 16'h8000});
        cyc = 0;
        changes = 1;
        prev = trial_s;
        while (!done_s && cyc < 200) begin
            set_start(poke && cyc == 3);
            @(negedge clk);
            cyc++;
            if (valid_s && trial_s !== prev) begin
                changes++;
                prev = trial_s;
            end
        end
        set_start(1'b0);
        check({tag, "_done_seen"}, done_s, 1);
        if (done_s && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result_s, e.result);
            check({tag, "_probes"}, probes_s, e.probes);
            check({tag, "_err"}, err_s, e.err);
            check({tag, "_latency"}, cyc, e.lat);
            check({tag, "_distinct_trials"}, changes, ep);
            check({tag, "_valid_low"}, valid_s, 0);
        end
        inject = 1'b0;
    endtask

    initial begin
        bus0.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        check_reset("rst0");
        sel = 1'b1;
        #1;
        check_reset("rst2");
        rst = 1'b0;
        @(negedge clk);

        run(0, "x8000", 16'h8000, 16'h8000, 1, 0, 0, 0);
        // Back-to-back: started straight out of DONE.
        run(0, "xffff", 16'hffff, 16'hffff, 16, 0, 0, 0);
        @(negedge clk);
        check("pulse_one_cycle", bus0.done, 0);
        check("done_to_idle_ready", bus0.start_ready, 1);
        check("trial_held", bus0.trial, 16'hffff);

        run(0, "x0000_poke", 16'h0000, 16'h0000, 16, 0, 0, 1);
        @(negedge clk);
        run(0, "x0001", 16'h0001, 16'h0001, 16, 0, 0, 0);
        @(negedge clk);
        run(0, "illegal", 16'h5000, 16'h4000, 3, 1, 1, 0);
        @(negedge clk);
        run(1, "lat2_a5c3", 16'ha5c3, 16'ha5c3, 16, 0, 0, 0);
        @(negedge clk);

        // Abort on the 5th probe: no done pulse, everything back to reset values.
        sel = 1'b0;
        unk0 = 16'h1234;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) begin
            check("no_done_before_abort", bus0.done, 0);
            @(negedge clk);
        end
        check("probe5_trial", bus0.trial, 16'h1800);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        run(0, "x1234_after_rst", 16'h1234, 16'h1234, 14, 0, 0, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
